// File: rtl/pipe_skid_reader.sv
// Two-entry skid buffer between an upstream pipeline register and a ready/valid consumer.
// Optional stall-cycle statistics counter enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_reader #(
  parameter int unsigned WIDTH = 128
`ifdef PIPE_SKID_STATS_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             stall_out,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_SKID_STATS_EN
  , output logic [CNT_W-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             valid_q, valid_d;
  logic             stall_q, stall_d;
  logic             accept;
  logic             out_fire;

  assign accept   = in_valid & ~stall_q;
  assign out_fire = valid_q & out_ready;

  // Flag registers are loaded from the next state so outputs never decode comb logic.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (accept && out_fire) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only resets occupancy; stale payload in main/skid is harmless.
    if (flush) begin
      state_d = EMPTY;
    end
    valid_d = (state_d != EMPTY);
    stall_d = (state_d == FULL);
  end

  assign out_data  = main_q;
  assign out_valid = valid_q;
  assign stall_out = stall_q;

`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of stalled cycles; only Reset clears it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt_q <= '0;
    end else if (stall_q && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reader.sv
// Self-checking bench for pipe_skid_reader: directed scenarios plus randomized
// traffic against a queue-based FIFO reference (capacity two).
module tb_pipe_skid_reader;

  localparam int unsigned WIDTH = 128;
`ifdef PIPE_SKID_STATS_EN
  localparam int unsigned CNT_W = 32;
`endif

  logic             Clk;
  logic             Reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             stall_out;
  logic             flush;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  pipe_skid_reader dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .stall_out (stall_out),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PIPE_SKID_STATS_EN
    , .stall_cycles (stall_cycles)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [WIDTH-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_out); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
`ifdef PIPE_SKID_STATS_EN
    checks++;
    if (stall_cycles !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
`endif
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] a5;
    a5 = {16{8'hA5}};
    in_valid = 1'b1; in_data = a5; out_ready = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0; in_data = '0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== a5) begin
      errors++; $display("FAIL single_out got v=%b d=%h exp v=1 d=%h", out_valid, out_data, a5);
    end
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL single_stall got=%b exp=0", stall_out); end
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge Clk);
      if (i > 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== WIDTH'(i - 1) || stall_out !== 1'b0) begin
          errors++;
          $display("FAIL b2b_word%0d got v=%b d=%h s=%b exp v=1 d=%0d s=0", i - 1, out_valid, out_data, stall_out, i - 1);
        end
      end
      in_valid = (i <= 8);
      in_data = WIDTH'(i);
    end
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    @(negedge Clk);
    in_valid = 1'b1; in_data = WIDTH'(1);
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== WIDTH'(1) || stall_out !== 1'b0) begin
      errors++; $display("FAIL bp_first got v=%b d=%h s=%b exp v=1 d=1 s=0", out_valid, out_data, stall_out);
    end
    in_data = WIDTH'(2);
    @(negedge Clk);
    checks++;
    if (stall_out !== 1'b1 || out_data !== WIDTH'(1)) begin
      errors++; $display("FAIL bp_full got s=%b d=%h exp s=1 d=1", stall_out, out_data);
    end
    in_data = WIDTH'(3);
    @(negedge Clk);
    checks++;
    if (stall_out !== 1'b1 || out_data !== WIDTH'(1)) begin
      errors++; $display("FAIL bp_hold got s=%b d=%h exp s=1 d=1", stall_out, out_data);
    end
    out_ready = 1'b1;
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== WIDTH'(2) || stall_out !== 1'b0) begin
      errors++; $display("FAIL bp_out2 got v=%b d=%h s=%b exp v=1 d=2 s=0", out_valid, out_data, stall_out);
    end
    @(negedge Clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== WIDTH'(3)) begin
      errors++; $display("FAIL bp_out3 got v=%b d=%h exp v=1 d=3", out_valid, out_data);
    end
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = WIDTH'(32'h11);
    @(negedge Clk);
    in_data = WIDTH'(32'h22);
    @(negedge Clk);
    checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL flush_prefull got=%b exp=1", stall_out); end
    flush = 1'b1; in_data = WIDTH'(32'h33);
    @(negedge Clk);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || stall_out !== 1'b0) begin
      errors++; $display("FAIL flush_empty got v=%b s=%b exp v=0 s=0", out_valid, stall_out);
    end
    in_data = WIDTH'(32'h44);
    @(negedge Clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== WIDTH'(32'h44) || stall_out !== 1'b0) begin
      errors++; $display("FAIL flush_next got v=%b d=%h s=%b exp v=1 d=44 s=0", out_valid, out_data, stall_out);
    end
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== WIDTH'(32'h44)) begin
      errors++; $display("FAIL flush_stable got v=%b d=%h exp v=1 d=44", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_alone got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = {4{32'hAAAA_5555}};
    @(negedge Clk);
    in_data = {4{32'hBBBB_CCCC}};
    @(negedge Clk);
    in_valid = 1'b0;
    checks++;
    if (stall_out !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL arst_prefull got s=%b v=%b exp s=1 v=1", stall_out, out_valid);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || stall_out !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL arst_clear got v=%b s=%b d=%h exp all 0", out_valid, stall_out, out_data);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

`ifdef PIPE_SKID_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = WIDTH'(5);
    @(negedge Clk);
    in_data = WIDTH'(6);
    @(negedge Clk);
    in_valid = 1'b0;
    repeat (5) @(negedge Clk);
    checks++;
    if (stall_cycles !== CNT_W'(5)) begin errors++; $display("FAIL stats_five got=%0d exp=5", stall_cycles); end
    flush = 1'b1;
    @(negedge Clk);
    flush = 1'b0;
    @(negedge Clk);
    checks++;
    if (stall_cycles !== CNT_W'(6)) begin errors++; $display("FAIL stats_flush got=%0d exp=6", stall_cycles); end
  endtask
`endif

  task automatic test_random();
    logic [WIDTH-1:0] mq[$];
    int unsigned      model_cnt;
    logic             iv, ordy, fl, acc, fire;
    logic [WIDTH-1:0] d;
    do_reset();
    model_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge Clk);
      checks++;
      if (out_valid !== (mq.size() != 0) || stall_out !== (mq.size() == 2)) begin
        errors++;
        $display("FAIL rand_flags cyc=%0d got v=%b s=%b exp v=%b s=%b", n, out_valid, stall_out, mq.size() != 0, mq.size() == 2);
      end
      if (mq.size() != 0) begin
        checks++;
        if (out_data !== mq[0]) begin
          errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", n, out_data, mq[0]);
        end
      end
`ifdef PIPE_SKID_STATS_EN
      checks++;
      if (stall_cycles !== CNT_W'(model_cnt)) begin
        errors++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", n, stall_cycles, model_cnt);
      end
`endif
      iv   = ($urandom_range(9, 0) < 7);
      ordy = ($urandom_range(9, 0) < 6);
      fl   = ($urandom_range(15, 0) == 0);
      d    = rand_word();
      in_valid = iv; out_ready = ordy; flush = fl; in_data = d;
      if (mq.size() == 2) model_cnt++;
      acc  = iv && (mq.size() < 2);
      fire = ordy && (mq.size() != 0);
      if (fire) void'(mq.pop_front());
      if (fl) mq.delete();
      else if (acc) mq.push_back(d);
    end
    @(negedge Clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    Reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef PIPE_SKID_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
